// File: rtl/seq_magnitude_comparator_if.sv
// rtl/seq_magnitude_comparator_if.sv - start/done handshake and result bundle for the sequential comparator
// Purpose: groups the request (start, operands, mode) and response (busy, done, flags) signals.
// Signals:
//   start        request, sampled by the comparator only in IDLE or DONE
//   a, b         WIDTH-bit operands, captured on an accepted start
//   signed_mode  1 = two's complement compare, captured on an accepted start
//   busy         high while the comparator walks the chunks
//   done         one-cycle pulse; flags valid from this cycle on
//   equal, a_greater, a_less  one-hot result flags
// Modports: master drives the request side, slave (the comparator) drives the response side.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             equal;
  logic             a_greater;
  logic             a_less;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, equal, a_greater, a_less
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, equal, a_greater, a_less
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle
// Purpose: compares two WIDTH-bit operands (unsigned or two's complement) one chunk per clock,
//   MSB chunk first, and reports a one-hot equal/greater/less result with a done pulse.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  seq_magnitude_comparator_if.slave (start, a, b, signed_mode in; busy, done, flags out)
// Parameters: WIDTH (multiple of CHUNK), CHUNK (1..WIDTH).
// Optional feature macro: CMP_EARLY_EXIT_EN -- finish as soon as a chunk decides the result;
//   when undefined every compare takes the same number of cycles regardless of data.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2
) (
  input logic                   clk,
  input logic                   rst,
  seq_magnitude_comparator_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDXW-1:0]  idx_q;
  logic             decided_q;
  logic             gt_q;
  logic             busy_q;
  logic             done_q;
  logic             equal_q;
  logic             a_greater_q;
  logic             a_less_q;

  // Flipping the sign bit of both operands maps two's complement order onto
  // unsigned order, so the chunk walk itself never needs to know the mode.
  logic [WIDTH-1:0] sign_flip;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             chunk_differs;
  logic             run_decided;
  logic             run_gt;
  logic             run_finish;
  logic             start_ok;

  always_comb begin
    sign_flip     = WIDTH'(bus.signed_mode) << (WIDTH - 1);
    chunk_a       = a_q[int'(idx_q) * CHUNK +: CHUNK];
    chunk_b       = b_q[int'(idx_q) * CHUNK +: CHUNK];
    chunk_differs = (chunk_a != chunk_b);
    // Sticky decision: once an earlier (more significant) chunk differed,
    // later chunks cannot change the outcome.
    run_decided   = decided_q | chunk_differs;
    run_gt        = decided_q ? gt_q : (chunk_a > chunk_b);
`ifdef CMP_EARLY_EXIT_EN
    run_finish    = (idx_q == '0) || chunk_differs;
`else
    run_finish    = (idx_q == '0);
`endif
    start_ok      = bus.start && (state_q != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      decided_q   <= 1'b0;
      gt_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      equal_q     <= 1'b0;
      a_greater_q <= 1'b0;
      a_less_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_ok) begin
        // Accepted from IDLE or DONE alike, which gives back-to-back throughput.
        state_q     <= S_RUN;
        a_q         <= bus.a ^ sign_flip;
        b_q         <= bus.b ^ sign_flip;
        idx_q       <= LAST_IDX;
        decided_q   <= 1'b0;
        gt_q        <= 1'b0;
        busy_q      <= 1'b1;
        equal_q     <= 1'b0;
        a_greater_q <= 1'b0;
        a_less_q    <= 1'b0;
      end else begin
        case (state_q)
          S_RUN: begin
            decided_q <= run_decided;
            gt_q      <= run_gt;
            if (run_finish) begin
              state_q     <= S_DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              equal_q     <= ~run_decided;
              a_greater_q <= run_decided & run_gt;
              a_less_q    <= run_decided & ~run_gt;
            end else begin
              idx_q <= idx_q - 1'b1;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.equal     = equal_q;
  assign bus.a_greater = a_greater_q;
  assign bus.a_less    = a_less_q;

endmodule
